alu_wb_sequencer: RTL
=====================

Name: alu_wb_sequencer

Overview:
- Wishbone slave that lets the management SoC drive the dual 4-bit lockstep ALU from the host side, instead of from io_in.
- Holds operand/select registers and drives them onto the ALU input bus.
- Waits the ALU latency, captures both results plus the compare outputs, and counts mismatches.
- Sweep mode runs N LFSR-generated vectors autonomously. Sits beside the ALU macro inside the user project wrapper.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone window base; adr[31:5] must match.
- ALU_LATENCY, 1, cycles from operand drive to valid ALU outputs (1..7).
- CNT_W, 16, width of sweep length and mismatch counter.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_stb_i  in  1  strobe
- wbs_cyc_i  in  1  cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- alu_a0, alu_b0, alu_a1, alu_b1  out  4 each  operands
- alu_sel1, alu_sel2  out  2 each  ALU selects
- alu_out1, alu_out2  in  4 each  ALU results
- alu_carry1, alu_carry2  in  1 each  carries
- alu_x  in  4  result compare (expected alu_out1^alu_out2)
- alu_y  in  1  carry compare (expected alu_carry1^alu_carry2)
- irq  out  1  level interrupt

Behaviour:
- Reset: all registers, outputs, counters and irq are 0; FSM in IDLE; SEED = 20'h00001.
- Wishbone:
  - Hit when stb&cyc&adr[31:5]==BASE_ADDR[31:5]. wbs_ack_o is registered and high exactly one cycle after the request is seen; it is never asserted two cycles in a row.
  - Misses are also acked; reads return 0 and writes are ignored.
  - Writes honour wbs_sel_i per byte.
- Register map (adr[4:2]):
  - 0 CTRL: b0 START (W1, self-clearing); b1 MODE (0 single, 1 sweep); b2 CLR (W1: zero counter/sticky); b3 IRQ_EN.
  - 1 OPER: [3:0]A0 [7:4]B0 [11:8]A1 [15:12]B1 [17:16]SEL1 [19:18]SEL2.
  - 2 COUNT: [CNT_W-1:0] sweep length.
  - 3 RESULT (RO): [3:0]out1 [7:4]out2 [8]c1 [9]c2 [13:10]x [14]y.
  - 4 STATUS: b0 BUSY (RO); b1 DONE (W1C); b2 MISMATCH (sticky, W1C); b3 CHKFAULT (sticky, W1C); [31:16] mismatch count (saturates at all-ones).
  - 5 SEED: [19:0].
- FSM: IDLE -> DRIVE -> WAIT -> CAPTURE.
  - IDLE: START latches and goes to DRIVE.
  - DRIVE (1 cycle): present the vector.
  - WAIT: ALU_LATENCY cycles.
  - CAPTURE (1 cycle): load RESULT.
    - Mismatch = (out1!=out2)|(c1!=c2); it increments the count and sets MISMATCH.
    - CHKFAULT set if x!=(out1^out2) or y!=(c1^c2).
  - After CAPTURE: single mode, or sweep with remaining==0, sets DONE and returns to IDLE. Otherwise advance the LFSR and return to DRIVE.
- Single mode: one vector taken from OPER.
- Sweep mode:
  - LFSR is 20-bit Fibonacci, x^20+x^17+1, loaded from SEED on START; a zero seed is forced to 1.
  - Vector per step: A0=A1=lfsr[3:0], B0=B1=lfsr[7:4], SEL1=SEL2=lfsr[9:8].
  - Runs exactly COUNT vectors. COUNT==0 sets DONE the cycle after START with no vectors driven.
- Throughput: one vector per ALU_LATENCY+2 cycles.
- While BUSY: START, OPER, COUNT and SEED writes are ignored. CLR and W1C still act.
- Simultaneous capture-set and W1C in the same cycle: set wins.
- alu_* outputs hold their last driven value in IDLE (OPER contents after a write in single mode).
- irq = IRQ_EN & DONE.
- wb_rst_i mid-run aborts immediately to IDLE with everything zeroed.

Optional Feature:
- Macro: ALU_WB_STOP_ON_MISMATCH_EN.
- Defined:
  - Sweep halts at the CAPTURE that detects the first mismatch; DONE is set.
  - STATUS[15:4] reads the vector index of that mismatch, counting from 0 (low 12 bits).
- Undefined: sweep always runs all COUNT vectors; STATUS[15:4] reads 0.

Test Plan:
- Reset, then read all registers -> all 0 except SEED=1; every access acks exactly one cycle after the request.
- OPER=0x0_0_5_3_5_3 (A0=3,B0=5,A1=3,B1=5, equal sels), MODE=0, START, fault-free model -> DONE after ALU_LATENCY+3 cycles; RESULT out1==out2; MISMATCH=0, count=0.
- Same vector with the model forcing out2 bit0 flipped -> MISMATCH=1, count=1. With IRQ_EN=1, irq rises with DONE and falls when DONE is W1C'd.
- Sweep COUNT=100, SEED=0xACE1, model injects a mismatch on vectors 10 and 50:
  - Macro off: count=2 after 100 vectors.
  - Macro on: halts, STATUS[15:4]=10, count=1.
- Sweep COUNT=0 -> DONE one cycle after START, no DRIVE state entered. Writing START while BUSY during a 5-vector run -> ignored, exactly 5 captures.
- Assert wb_rst_i mid-sweep -> next cycle BUSY=0, all alu_* = 0, count=0. Model returns x != out1^out2 -> CHKFAULT=1.

Source files
------------

// File: rtl/alu_wb_sequencer.sv
// Wishbone slave that sequences vectors into the dual lockstep 4-bit ALU.
// Optional ALU_WB_STOP_ON_MISMATCH_EN: sweeps halt at the first mismatch.
module alu_wb_sequencer #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          ALU_LATENCY = 1,
    parameter int          CNT_W       = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  alu_a0,
    output logic [3:0]  alu_b0,
    output logic [3:0]  alu_a1,
    output logic [3:0]  alu_b1,
    output logic [1:0]  alu_sel1,
    output logic [1:0]  alu_sel2,
    input  logic [3:0]  alu_out1,
    input  logic [3:0]  alu_out2,
    input  logic        alu_carry1,
    input  logic        alu_carry2,
    input  logic [3:0]  alu_x,
    input  logic        alu_y,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        WAIT,
        CAPT
    } state_t;

    state_t state, state_nx;

    logic             req, hit, busy, drive, capt;
    logic [2:0]       idx;
    logic [31:0]      rdata, oper_m, count_m, seed_m, status;
    logic             wr_ctrl, wr_oper, wr_count, wr_stat, wr_seed;
    logic             mode, irq_en, run_mode, done, mm_flag, cf_flag;
    logic [19:0]      oper, seed, lfsr, lfsr_nx, seed_eff, vec;
    logic [CNT_W-1:0] count, remain, mm_cnt;
    logic [2:0]       wcnt;
    logic [14:0]      result;
    logic [11:0]      idx_field;
    logic             start_req, go, zero_run, finish;
    logic             mm_now, cf_now, clr;
    logic             unused_adr;

`ifdef ALU_WB_STOP_ON_MISMATCH_EN
    logic [CNT_W-1:0] vidx;
    logic [11:0]      mm_idx;
`endif

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [3:0]  be
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = be[i] ? d[i*8 +: 8] : old[i*8 +: 8];
        return r;
    endfunction

    // Sweep vectors feed identical operands to both lanes.
    function automatic logic [19:0] lfsr_vec(input logic [19:0] l);
        return {l[9:8], l[9:8], l[7:4], l[3:0], l[7:4], l[3:0]};
    endfunction

    assign unused_adr = ^wbs_adr_i[1:0];

    always_comb begin
        req       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
        hit       = wbs_adr_i[31:5] == BASE_ADDR[31:5];
        idx       = wbs_adr_i[4:2];
        wr_ctrl   = req & hit & wbs_we_i & (idx == 3'd0);
        wr_oper   = req & hit & wbs_we_i & (idx == 3'd1);
        wr_count  = req & hit & wbs_we_i & (idx == 3'd2);
        wr_stat   = req & hit & wbs_we_i & (idx == 3'd4);
        wr_seed   = req & hit & wbs_we_i & (idx == 3'd5);
        oper_m    = merge({12'b0, oper}, wbs_dat_i, wbs_sel_i);
        count_m   = merge(32'(count), wbs_dat_i, wbs_sel_i);
        seed_m    = merge({12'b0, seed}, wbs_dat_i, wbs_sel_i);
        clr       = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[2];
        start_req = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[0]
                  & (state == IDLE);
        go        = start_req & (~wbs_dat_i[1] | (count != '0));
        zero_run  = start_req & wbs_dat_i[1] & (count == '0);
        seed_eff  = (seed == '0) ? 20'd1 : seed;
        lfsr_nx   = {lfsr[18:0], lfsr[19] ^ lfsr[16]};
        mm_now    = (alu_out1 != alu_out2) | (alu_carry1 != alu_carry2);
        cf_now    = (alu_x != (alu_out1 ^ alu_out2))
                  | (alu_y != (alu_carry1 ^ alu_carry2));
`ifdef ALU_WB_STOP_ON_MISMATCH_EN
        finish    = ~run_mode | (remain == CNT_W'(1)) | mm_now;
        idx_field = mm_idx;
`else
        finish    = ~run_mode | (remain == CNT_W'(1));
        idx_field = '0;
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (go) state_nx = DRIVE;
            DRIVE: state_nx = WAIT;
            WAIT:  if (wcnt == '0) state_nx = CAPT;
            CAPT:  state_nx = finish ? IDLE : DRIVE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        drive = 1'b0;
        capt  = 1'b0;
        unique case (state)
            IDLE:  busy  = 1'b0;
            DRIVE: begin
                busy  = 1'b1;
                drive = 1'b1;
            end
            WAIT:  busy  = 1'b1;
            CAPT:  begin
                busy  = 1'b1;
                capt  = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    always_comb begin
        status = {16'(mm_cnt), idx_field,
                  cf_flag, mm_flag, done, busy};
        rdata  = '0;
        case (idx)
            3'd0: rdata = {28'b0, irq_en, 1'b0, mode, 1'b0};
            3'd1: rdata = {12'b0, oper};
            3'd2: rdata = 32'(count);
            3'd3: rdata = {17'b0, result};
            3'd4: rdata = status;
            3'd5: rdata = {12'b0, seed};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            mode      <= 1'b0;
            irq_en    <= 1'b0;
            run_mode  <= 1'b0;
            done      <= 1'b0;
            mm_flag   <= 1'b0;
            cf_flag   <= 1'b0;
            oper      <= '0;
            seed      <= 20'h00001;
            lfsr      <= '0;
            vec       <= '0;
            count     <= '0;
            remain    <= '0;
            mm_cnt    <= '0;
            wcnt      <= '0;
            result    <= '0;
`ifdef ALU_WB_STOP_ON_MISMATCH_EN
            vidx      <= '0;
            mm_idx    <= '0;
`endif
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req & hit & ~wbs_we_i) ? rdata : '0;
            if (wr_ctrl && wbs_sel_i[0]) begin
                mode   <= wbs_dat_i[1];
                irq_en <= wbs_dat_i[3];
            end
            if (wr_oper && !busy) begin
                oper <= oper_m[19:0];
                if (!mode) vec <= oper_m[19:0];
            end
            if (wr_count && !busy) count <= count_m[CNT_W-1:0];
            if (wr_seed && !busy)  seed  <= seed_m[19:0];
            if (wr_stat && wbs_sel_i[0]) begin
                if (wbs_dat_i[1]) done    <= 1'b0;
                if (wbs_dat_i[2]) mm_flag <= 1'b0;
                if (wbs_dat_i[3]) cf_flag <= 1'b0;
            end
            if (clr) begin
                mm_cnt  <= '0;
                mm_flag <= 1'b0;
                cf_flag <= 1'b0;
`ifdef ALU_WB_STOP_ON_MISMATCH_EN
                mm_idx  <= '0;
`endif
            end
            if (zero_run) done <= 1'b1;
            if (go) begin
                run_mode <= wbs_dat_i[1];
                remain   <= count;
                lfsr     <= seed_eff;
                vec      <= wbs_dat_i[1] ? lfsr_vec(seed_eff) : oper;
`ifdef ALU_WB_STOP_ON_MISMATCH_EN
                vidx     <= '0;
`endif
            end
            if (drive) wcnt <= 3'(ALU_LATENCY - 1);
            else if (state == WAIT) wcnt <= wcnt - 3'd1;
            // Capture-side sets are placed last so they beat W1C/CLR.
            if (capt) begin
                result <= {alu_y, alu_x, alu_carry2, alu_carry1,
                           alu_out2, alu_out1};
                remain <= remain - CNT_W'(1);
                if (mm_now) begin
                    mm_flag <= 1'b1;
                    if (mm_cnt != '1) mm_cnt <= mm_cnt + CNT_W'(1);
`ifdef ALU_WB_STOP_ON_MISMATCH_EN
                    mm_idx  <= 12'(vidx);
`endif
                end
                if (cf_now) cf_flag <= 1'b1;
`ifdef ALU_WB_STOP_ON_MISMATCH_EN
                vidx <= vidx + CNT_W'(1);
`endif
                if (finish) begin
                    done <= 1'b1;
                end else begin
                    lfsr <= lfsr_nx;
                    vec  <= lfsr_vec(lfsr_nx);
                end
            end
        end
    end

    assign alu_a0   = vec[3:0];
    assign alu_b0   = vec[7:4];
    assign alu_a1   = vec[11:8];
    assign alu_b1   = vec[15:12];
    assign alu_sel1 = vec[17:16];
    assign alu_sel2 = vec[19:18];
    assign irq      = irq_en & done;

endmodule
